heater_ctrl: RTL and testbench
==============================

Name: heater_ctrl

Overview:
- Supervisory stage between the operator control interface (VIO probe outputs) and the array of heater instances.
- Converts requested enable masks into staggered heater enables, limiting inrush to one heater turn-on per STAGGER_CYCLES.
- Latches heater errors into sticky status, force-disables faulted channels and generates timed err_clear pulses.
- Locks out channels that fault repeatedly.

Parameters:
N, 18, number of heater channels
STAGGER_CYCLES, 1024, minimum clk cycles between successive heater turn-ons
CLR_PULSE_CYCLES, 4, width of each heater_err_clear pulse
MAX_RETRY, 3, faults-while-enabled before a channel is locked out

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_enable  input  N  requested enable per channel (level)
clear_req  input  N  clear request per channel; rising edge acts
heater_error  input  N  error flag from each heater instance
heater_enable  output  N  enable to each heater instance
heater_err_clear  output  N  error-clear pulse to each heater instance
err_sticky  output  N  latched error status per channel
lockout  output  N  channel locked out after MAX_RETRY faults
busy  output  1  high while a stagger interval is counting

Behaviour:
- Reset (async assert, sync release): all outputs 0, retry counters 0, clear-pulse counters 0, scheduler IDLE, previous clear_req register 0.
- Eligible(i) = req_enable[i] & ~heater_enable[i] & ~err_sticky[i] & ~lockout[i] & ~heater_err_clear[i].
- Scheduler FSM, two states:
  - IDLE: if any channel is eligible, set heater_enable of the lowest-index eligible channel on the next edge, load the stagger counter with STAGGER_CYCLES-1 and go to WAIT.
  - WAIT: busy=1; decrement the counter; at 0 return to IDLE. Exactly one turn-on per visit.
  - Spacing between turn-ons is therefore at least STAGGER_CYCLES+1 cycles.
- Turn-off is immediate: req_enable[i]=0 clears heater_enable[i] on the next edge in any scheduler state. The stagger counter is unaffected.
- Fault while enabled (heater_error[i]=1 and heater_enable[i]=1):
  - Next edge: heater_enable[i]=0 and err_sticky[i]=1.
  - retry[i] increments, saturating at MAX_RETRY; when it reaches MAX_RETRY, lockout[i]=1 on the same edge.
- Error while disabled: sets err_sticky[i] only; retry[i] is unchanged.
- Clear (rising edge of clear_req[i]):
  - Loads the pulse counter; heater_err_clear[i]=1 for exactly CLR_PULSE_CYCLES cycles, starting the cycle after the edge.
  - On the final pulse cycle, err_sticky[i] is cleared if heater_error[i]=0; otherwise it stays set.
  - If req_enable[i]=0 at the edge, lockout[i] and retry[i] are also cleared. Lockout is never released while the channel is requested.
  - An edge arriving while a pulse is in progress restarts the pulse.
- Simultaneous events:
  - New fault and end-of-pulse on the same channel in one cycle: the fault wins and err_sticky stays 1.
  - Fault on the channel the scheduler is turning on in that cycle: the enable is not set and err_sticky is set.
- Channels are independent; any number of clear pulses may run concurrently.
- Width rules: stagger counter is $clog2(STAGGER_CYCLES) bits (minimum 1); retry is $clog2(MAX_RETRY+1) bits; pulse counter is $clog2(CLR_PULSE_CYCLES+1) bits.

Optional Feature:
- Macro HEATER_CTRL_ERRCNT_EN.
- Defined: adds output err_count [15:0], a saturating count of fault-while-enabled events across all channels. Multiple same-cycle faults add their popcount, clamped at 16'hFFFF. Reset value 0; never cleared except by reset.
- Undefined: the port and the counter do not exist.

Decomposition:
- Package heater_pkg:
  - scheduler state enum (IDLE, WAIT)
  - default constants HEATER_N=18, HEATER_STAGGER=1024, HEATER_CLR_PULSE=4, HEATER_MAX_RETRY=3
- Sub-module heater_chan, one per channel: owns sticky/retry/lockout/pulse counter and the edge detect. It exports eligible and accepts a grant from the top.
- The top holds the priority encoder, the FSM and the optional counter.

Test Plan (STAGGER_CYCLES=8, N=4, CLR_PULSE_CYCLES=4, MAX_RETRY=3):
- req_enable 0000->1111 at t0 -> enables rise ch0,1,2,3 at t0+1, +10, +19, +28; busy high between turn-ons.
- All enabled, req_enable[2] drops -> heater_enable[2]=0 next cycle; other channels and the counter are undisturbed.
- heater_error[1]=1 while enabled -> next cycle enable[1]=0 and err_sticky[1]=1; clear_req[1] edge with error low -> heater_err_clear[1] high 4 cycles, sticky clears, channel re-enables via the stagger.
- Three fault/clear cycles on ch0 with req held -> lockout[0]=1 after the third fault; a clear with req=1 leaves lockout set; drop req, then clear -> lockout and retry return to 0.
- Clear edge while heater_error[3] is still high -> 4-cycle pulse, err_sticky[3] stays 1, ch3 is never enabled.
- Assert rst_n=0 mid-WAIT -> all outputs 0 asynchronously; after release, ramp restarts from the lowest requested channel.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared types and default constants for the heater supervisory controller.
// Optional feature macro: HEATER_CTRL_ERRCNT_EN (adds a global fault counter).
package heater_pkg;

   localparam int unsigned HEATER_N         = 18;
   localparam int unsigned HEATER_STAGGER   = 1024;
   localparam int unsigned HEATER_CLR_PULSE = 4;
   localparam int unsigned HEATER_MAX_RETRY = 3;

   // Turn-on scheduler states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } sched_state_t;

endpackage : heater_pkg

// File: rtl/heater_if.sv
// Operator/heater-array bundle for heater_ctrl.
// master : drives req_enable, clear_req, heater_error; observes the status.
// slave  : the controller; drives heater_enable, heater_err_clear,
//          err_sticky, lockout, busy (and err_count with HEATER_CTRL_ERRCNT_EN).
interface heater_if
   import heater_pkg::*;
#(
   parameter int unsigned N = HEATER_N
) ();

   logic [N-1:0] req_enable;
   logic [N-1:0] clear_req;
   logic [N-1:0] heater_error;
   logic [N-1:0] heater_enable;
   logic [N-1:0] heater_err_clear;
   logic [N-1:0] err_sticky;
   logic [N-1:0] lockout;
   logic         busy;
`ifdef HEATER_CTRL_ERRCNT_EN
   logic [15:0]  err_count;

   modport master (
      output req_enable, clear_req, heater_error,
      input  heater_enable, heater_err_clear, err_sticky, lockout, busy, err_count
   );
   modport slave (
      input  req_enable, clear_req, heater_error,
      output heater_enable, heater_err_clear, err_sticky, lockout, busy, err_count
   );
`else
   modport master (
      output req_enable, clear_req, heater_error,
      input  heater_enable, heater_err_clear, err_sticky, lockout, busy
   );
   modport slave (
      input  req_enable, clear_req, heater_error,
      output heater_enable, heater_err_clear, err_sticky, lockout, busy
   );
`endif

endinterface : heater_if

// File: rtl/heater_chan.sv
// Per-channel supervisor: enable, sticky error, retry/lockout and clear pulse.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_req         : requested enable (level)
//   i_clear       : clear request (rising edge acts)
//   i_error       : error flag from the heater instance
//   i_grant       : one-cycle turn-on grant from the scheduler
//   o_enable      : heater enable
//   o_err_clear   : error-clear pulse to the heater
//   o_sticky      : latched error
//   o_lockout     : channel locked out after repeated faults
//   o_eligible_c  : combinational, channel may be granted a turn-on
//   o_fault_c     : combinational, fault-while-enabled this cycle
//                   (only with HEATER_CTRL_ERRCNT_EN)
module heater_chan
   import heater_pkg::*;
#(
   parameter int unsigned CLR_PULSE_CYCLES = HEATER_CLR_PULSE,
   parameter int unsigned MAX_RETRY        = HEATER_MAX_RETRY
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic i_clear,
   input  logic i_error,
   input  logic i_grant,
   output logic o_enable,
   output logic o_err_clear,
   output logic o_sticky,
   output logic o_lockout,
   output logic o_eligible_c
`ifdef HEATER_CTRL_ERRCNT_EN
   ,
   output logic o_fault_c
`endif
);

   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned PULSE_W = (CLR_PULSE_CYCLES > 0) ? $clog2(CLR_PULSE_CYCLES + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(CLR_PULSE_CYCLES);

   logic               r_enable;
   logic               r_sticky;
   logic               r_lockout;
   logic               r_err_clear;
   logic               r_clear_d;
   logic [RETRY_W-1:0] r_retry;
   logic [PULSE_W-1:0] r_pulse;

   logic               w_fault;
   logic               w_clr_edge;
   logic               w_final;
   logic [RETRY_W-1:0] w_retry_inc;

   // Event decode; a restarting edge suppresses the end-of-pulse clear
   always_comb begin
      w_fault     = i_error & r_enable;
      w_clr_edge  = i_clear & ~r_clear_d;
      w_final     = (r_pulse == PULSE_W'(1)) & ~w_clr_edge;
      w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + RETRY_W'(1);
   end

   // Channel state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable    <= 1'b0;
         r_sticky    <= 1'b0;
         r_lockout   <= 1'b0;
         r_err_clear <= 1'b0;
         r_clear_d   <= 1'b0;
         r_retry     <= '0;
         r_pulse     <= '0;
      end else begin
         r_clear_d <= i_clear;

         // A grant is dropped if the heater reports an error in the same cycle
         if (w_fault || !i_req) begin
            r_enable <= 1'b0;
         end else if (i_grant && !i_error) begin
            r_enable <= 1'b1;
         end

         // Any error latches; end of pulse clears only when the error is gone
         r_sticky <= i_error | (r_sticky & ~w_final);

         if (w_fault) begin
            r_retry <= w_retry_inc;
            if (w_retry_inc == RETRY_MAX) begin
               r_lockout <= 1'b1;
            end
         end else if (w_clr_edge && !i_req) begin
            r_retry   <= '0;
            r_lockout <= 1'b0;
         end

         if (w_clr_edge) begin
            r_pulse <= PULSE_LOAD;
         end else if (r_pulse != '0) begin
            r_pulse <= r_pulse - PULSE_W'(1);
         end
         r_err_clear <= w_clr_edge | (r_pulse > PULSE_W'(1));
      end
   end

   assign o_enable     = r_enable;
   assign o_err_clear  = r_err_clear;
   assign o_sticky     = r_sticky;
   assign o_lockout    = r_lockout;
   assign o_eligible_c = i_req & ~r_enable & ~r_sticky & ~r_lockout & ~r_err_clear;
`ifdef HEATER_CTRL_ERRCNT_EN
   assign o_fault_c    = w_fault;
`endif

endmodule : heater_chan

// File: rtl/heater_ctrl.sv
// Heater supervisory stage: staggered turn-on scheduler over N channels.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : heater_if.slave -- requests/clears/errors in; enables,
//                clear pulses, sticky/lockout status and busy out.
// Optional macro HEATER_CTRL_ERRCNT_EN adds bus.err_count, a saturating
// count of fault-while-enabled events across all channels.
module heater_ctrl
   import heater_pkg::*;
#(
   parameter int unsigned N                = HEATER_N,
   parameter int unsigned STAGGER_CYCLES   = HEATER_STAGGER,
   parameter int unsigned CLR_PULSE_CYCLES = HEATER_CLR_PULSE,
   parameter int unsigned MAX_RETRY        = HEATER_MAX_RETRY
) (
   input  logic    clk,
   input  logic    rst_n,
   heater_if.slave bus
);

   localparam int unsigned CNT_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGGER_CYCLES - 1);

   sched_state_t     r_state;
   sched_state_t     w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_busy;
   logic             w_busy_nxt;

   logic [N-1:0]     w_elig;
   logic [N-1:0]     w_grant;
   logic [N-1:0]     w_enable;
   logic [N-1:0]     w_err_clear;
   logic [N-1:0]     w_sticky;
   logic [N-1:0]     w_lockout;
`ifdef HEATER_CTRL_ERRCNT_EN
   logic [N-1:0]     w_fault;
`endif

   for (genvar g = 0; g < int'(N); g++) begin : g_chan
      heater_chan #(
         .CLR_PULSE_CYCLES (CLR_PULSE_CYCLES),
         .MAX_RETRY        (MAX_RETRY)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_req        (bus.req_enable[g]),
         .i_clear      (bus.clear_req[g]),
         .i_error      (bus.heater_error[g]),
         .i_grant      (w_grant[g]),
         .o_enable     (w_enable[g]),
         .o_err_clear  (w_err_clear[g]),
         .o_sticky     (w_sticky[g]),
         .o_lockout    (w_lockout[g]),
         .o_eligible_c (w_elig[g])
`ifdef HEATER_CTRL_ERRCNT_EN
         ,
         .o_fault_c    (w_fault[g])
`endif
      );
   end

   // Scheduler state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next state; IDLE grants the lowest eligible channel (x & -x isolates it)
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant     = '0;
      w_busy_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_elig) begin
               w_grant     = w_elig & (~w_elig + N'(1));
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_WAIT);
   end

`ifdef HEATER_CTRL_ERRCNT_EN
   localparam int unsigned POP_W = $clog2(N + 1);

   logic [POP_W-1:0] w_pop;
   logic [16:0]      w_sum;
   logic [15:0]      r_err_count;

   // Popcount of same-cycle faults added with saturation
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < int'(N); i++) begin
         w_pop = w_pop + POP_W'(w_fault[i]);
      end
      w_sum = 17'(r_err_count) + 17'(w_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else begin
         r_err_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
   end

   assign bus.err_count = r_err_count;
`endif

   assign bus.heater_enable    = w_enable;
   assign bus.heater_err_clear = w_err_clear;
   assign bus.err_sticky       = w_sticky;
   assign bus.lockout          = w_lockout;
   assign bus.busy             = r_busy;

endmodule : heater_ctrl

// File: tb/tb_heater_ctrl.sv
// Scoreboard bench for heater_ctrl: driver steps a behavioural model and
// queues expected outputs; a monitor compares them after each clock edge.
module tb_heater_ctrl;
   import heater_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned STG = 8;
   localparam int unsigned CLR = 4;
   localparam int unsigned MR  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   heater_if #(.N(N)) bus ();

   heater_ctrl #(
      .N                (N),
      .STAGGER_CYCLES   (STG),
      .CLR_PULSE_CYCLES (CLR),
      .MAX_RETRY        (MR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [16:0] exp_q[$];

   // Reference model state
   bit m_en[N], m_sticky[N], m_lock[N], m_prev[N];
   int m_retry[N], m_pulse[N];
   int m_busy_left;
   logic [N-1:0] cur_req, cur_clr, cur_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [16:0] dut_out();
      return {bus.heater_enable, bus.heater_err_clear, bus.err_sticky, bus.lockout, bus.busy};
   endfunction

   function automatic logic [16:0] model_out();
      logic [N-1:0] en, cl, st, lk;
      for (int i = 0; i < int'(N); i++) begin
         en[i] = m_en[i];
         cl[i] = (m_pulse[i] > 0);
         st[i] = m_sticky[i];
         lk[i] = m_lock[i];
      end
      return {en, cl, st, lk, (m_busy_left > 0)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(N); i++) begin
         m_en[i] = 0; m_sticky[i] = 0; m_lock[i] = 0; m_prev[i] = 0;
         m_retry[i] = 0; m_pulse[i] = 0;
      end
      m_busy_left = 0;
   endtask

   // One clock of the rules: busy_left counts remaining blocked cycles after a turn-on
   task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] clr, input logic [N-1:0] err);
      bit elig[N];
      bit fault, ed;
      int g;
      g = -1;
      for (int i = 0; i < int'(N); i++)
         elig[i] = req[i] && !m_en[i] && !m_sticky[i] && !m_lock[i] && (m_pulse[i] == 0);
      if (m_busy_left > 0) m_busy_left--;
      else for (int i = int'(N) - 1; i >= 0; i--) if (elig[i]) g = i;
      if (g >= 0) m_busy_left = STG;
      for (int i = 0; i < int'(N); i++) begin
         fault = err[i] && m_en[i];
         ed    = clr[i] && !m_prev[i];
         if (fault || !req[i]) m_en[i] = 0;
         else if (i == g && !err[i]) m_en[i] = 1;
         if (err[i]) m_sticky[i] = 1;
         else if (m_pulse[i] == 1 && !ed) m_sticky[i] = 0;
         if (fault) begin
            if (m_retry[i] < int'(MR)) m_retry[i]++;
            if (m_retry[i] == int'(MR)) m_lock[i] = 1;
         end else if (ed && !req[i]) begin
            m_retry[i] = 0;
            m_lock[i]  = 0;
         end
         if (ed) m_pulse[i] = CLR;
         else if (m_pulse[i] > 0) m_pulse[i]--;
         m_prev[i] = clr[i];
      end
   endtask

   task automatic step_body(input logic [N-1:0] req, input logic [N-1:0] clr, input logic [N-1:0] err);
      bus.req_enable   = req;
      bus.clear_req    = clr;
      bus.heater_error = err;
      cur_req = req; cur_clr = clr; cur_err = err;
      model_step(req, clr, err);
      exp_q.push_back(model_out());
   endtask

   task automatic step(input logic [N-1:0] req, input logic [N-1:0] clr, input logic [N-1:0] err);
      @(negedge clk);
      step_body(req, clr, err);
   endtask

   task automatic idle(input int n, input logic [N-1:0] req);
      repeat (n) step(req, '0, '0);
   endtask

   task automatic sample();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int n, input logic [N-1:0] req_after);
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_enable = '0; bus.clear_req = '0; bus.heater_error = '0;
      #1;
      check("async_reset_outputs", 32'(dut_out()), 32'h0);
      model_reset();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      step_body(req_after, '0, '0);
   endtask

   // Monitor: every edge after reset release produces one queued expectation
   initial begin
      logic [16:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{en,clr,sticky,lock,busy}", 32'(dut_out()), 32'(e));
         end
      end
   end

   initial begin
      int rise[N];
      logic [N-1:0] r, k, e;

      bus.req_enable = '0; bus.clear_req = '0; bus.heater_error = '0;
      model_reset();
      #12;
      check("reset_state", 32'(dut_out()), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step_body('0, '0, '0);

      // Ramp: enables at +1, +10, +19, +28
      for (int i = 0; i < int'(N); i++) rise[i] = -1;
      for (int c = 1; c <= 30; c++) begin
         step('1, '0, '0);
         sample();
         for (int i = 0; i < int'(N); i++)
            if (bus.heater_enable[i] && rise[i] < 0) rise[i] = c;
         if (c == 5)  check("busy_mid_wait", 32'(bus.busy), 32'd1);
         if (c == 9)  check("busy_idle_gap", 32'(bus.busy), 32'd0);
         if (c == 10) check("busy_after_2nd", 32'(bus.busy), 32'd1);
      end
      check("rise_ch0", 32'(rise[0]), 32'd1);
      check("rise_ch1", 32'(rise[1]), 32'd10);
      check("rise_ch2", 32'(rise[2]), 32'd19);
      check("rise_ch3", 32'(rise[3]), 32'd28);

      // Immediate turn-off of ch2, stagger counter undisturbed
      step(4'hB, '0, '0);
      sample();
      check("drop_ch2_enable", 32'(bus.heater_enable), 32'hB);
      check("drop_ch2_busy", 32'(bus.busy), 32'd1);
      idle(14, '1);

      // Fault on ch1, then clear with error low -> re-enable
      step('1, '0, 4'h2);
      sample();
      check("fault_ch1_sticky", 32'(bus.err_sticky), 32'h2);
      check("fault_ch1_enable", 32'(bus.heater_enable[1]), 32'd0);
      step('1, 4'h2, '0);
      idle(25, '1);
      check("ch1_reenabled", 32'(bus.heater_enable[1]), 32'd1);

      // Three faults on ch0 with req held -> lockout survives clear
      for (int t = 0; t < 3; t++) begin
         step('1, '0, 4'h1);
         step('1, '0, '0);
         step('1, 4'h1, '0);
         idle(25, '1);
      end
      sample();
      check("lockout_ch0_held", 32'(bus.lockout[0]), 32'd1);
      check("lockout_ch0_off", 32'(bus.heater_enable[0]), 32'd0);
      step(4'hE, '0, '0);
      step(4'hE, 4'h1, '0);
      idle(8, 4'hE);
      sample();
      check("lockout_ch0_released", 32'(bus.lockout[0]), 32'd0);
      idle(20, '1);

      // Clear on ch3 while its error is still high: sticky stays set
      step('1, '0, 4'h8);
      step('1, 4'h8, 4'h8);
      repeat (8) step('1, '0, 4'h8);
      sample();
      check("ch3_sticky_held", 32'(bus.err_sticky[3]), 32'd1);
      check("ch3_not_enabled", 32'(bus.heater_enable[3]), 32'd0);
      step('1, 4'h8, '0);
      idle(25, '1);

      // Reset in the middle of a stagger wait, then ramp again
      idle(3, '0);
      step('1, '0, '0);
      idle(3, '1);
      do_reset(2, '1);
      sample();
      check("ramp_restart_ch0", 32'(bus.heater_enable), 32'h1);
      idle(30, '1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r = cur_req; k = cur_clr; e = '0;
         for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(39) == 0) r[i] = ~r[i];
            if ($urandom_range(9) == 0)  k[i] = ~k[i];
            if ($urandom_range(59) == 0) e[i] = 1'b1;
         end
         if (c == 1500) do_reset(2, r);
         else step(r, k, e);
      end

      sample();
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_heater_ctrl
